// File: rtl/sample_bank_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : sample_bank_reader_if
//  Purpose  : Valid/ready sample stream carrying one bank slot per beat.
//             The producer drives sample, index and last-beat flag together
//             with valid; the consumer answers with ready.
//  Signals  : out_smpl  - sample value
//             out_idx   - slot index of out_smpl
//             out_last  - final beat of the frame
//             out_valid - out_smpl/out_idx/out_last are valid
//             out_ready - consumer accepts the presented beat
//  Revision : 1.0 - initial release
// ============================================================================
interface sample_bank_reader_if #(
  parameter int DATA_WIDTH = 12,
  parameter int IDX_W      = 4
);
  logic [DATA_WIDTH-1:0] out_smpl;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_smpl, out_idx, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_smpl, out_idx, out_last, out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/sample_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sample_bank_reader
//  Purpose  : Streams the first `count` slots of a packed sample bank out in
//             index order over a valid/ready stream. The bank is copied into
//             a shadow register when the readout starts, so writes to the
//             live bank during a frame cannot tear it.
//  Ports    : clk      - system clock (rising edge)
//             rst_n    - asynchronous active-low reset
//             start    - one-cycle readout request, honoured only when idle
//             count    - number of slots to read from slot 0 (clamped to N)
//             in_smpls - packed bank, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//             strm     - outgoing sample stream (master side)
//             busy     - readout in progress
//             done     - one-cycle pulse when a readout finishes
//  Revision : 1.0 - initial release
// ============================================================================
module sample_bank_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 14,
  parameter int IDX_W      = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    start,
  input  wire logic [IDX_W:0]          count,
  input  wire logic [N*DATA_WIDTH-1:0] in_smpls,
  sample_bank_reader_if.master         strm,
  output logic                         busy,
  output logic                         done
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(N);
  localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [N*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [IDX_W:0]          len_q, len_d;
  logic [DATA_WIDTH-1:0]   smpl_q, smpl_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   shadow_slot [N];
  logic [IDX_W:0]          len_clamped;
  logic [IDX_W-1:0]        idx_inc;

  // Slot view of the shadow copy so the next sample can be picked by index.
  for (genvar g = 0; g < N; g++) begin : g_slot
    assign shadow_slot[g] = shadow_q[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign len_clamped = (count > LEN_MAX) ? LEN_MAX : count;
  assign idx_inc     = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    len_d    = len_q;
    smpl_d   = smpl_q;
    idx_d    = idx_q;
    last_d   = last_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            // Empty request: acknowledge with done but never go busy.
            done_d = 1'b1;
          end else begin
            shadow_d = in_smpls;
            len_d    = len_clamped;
            idx_d    = '0;
            // Slot 0 comes straight from the live bank; it is the same
            // value being captured into the shadow on this edge.
            smpl_d   = in_smpls[DATA_WIDTH-1:0];
            last_d   = (len_clamped == LEN_ONE);
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            state_d  = SEND;
          end
        end
      end

      SEND: begin
        // out_valid is always high in SEND, so ready alone marks a transfer.
        if (strm.out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = idx_inc;
            smpl_d = shadow_slot[idx_inc];
            last_d = ({1'b0, idx_inc} == (len_q - LEN_ONE));
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      len_q    <= '0;
      smpl_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      len_q    <= len_d;
      smpl_q   <= smpl_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign strm.out_smpl  = smpl_q;
  assign strm.out_idx   = idx_q;
  assign strm.out_last  = last_q;
  assign strm.out_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_bank_reader
//  Purpose  : Self-checking bench for sample_bank_reader. A frame-level
//             reference model (captured frame array, position and length)
//             predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sample_bank_reader;

  localparam int DW = 12;
  localparam int N  = 14;
  localparam int IW = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [IW:0]       count;
  logic [N*DW-1:0]   in_smpls;
  logic              busy;
  logic              done;

  sample_bank_reader_if #(.DATA_WIDTH(DW), .IDX_W(IW)) sif ();

  sample_bank_reader #(.DATA_WIDTH(DW), .N(N), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count    (count),
    .in_smpls (in_smpls),
    .strm     (sif),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a frame is the list of slot values captured at start;
  // m_pos is the beat currently offered, m_len the clamped frame length.
  // --------------------------------------------------------------------------
  logic [DW-1:0] m_frame [N];
  int            m_pos;
  int            m_len;
  bit            m_active;
  bit            m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_pos    <= 0;
      m_len    <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (start) begin
          if (count == 0) begin
            m_done <= 1'b1;
          end else begin
            m_len <= (int'(count) > N) ? N : int'(count);
            for (int i = 0; i < N; i++) m_frame[i] <= in_smpls[i*DW +: DW];
            m_pos    <= 0;
            m_active <= 1'b1;
          end
        end
      end else if (sif.out_ready) begin
        if (m_pos + 1 == m_len) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
        m_pos <= m_pos + 1;
      end
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check_eq("valid", 32'(sif.out_valid), 32'(m_active));
    check_eq("busy",  32'(busy),          32'(m_active));
    check_eq("done",  32'(done),          32'(m_done));
    if (m_active) begin
      check_eq("smpl", 32'(sif.out_smpl), 32'(m_frame[m_pos]));
      check_eq("idx",  32'(sif.out_idx),  32'(m_pos));
      check_eq("last", 32'(sif.out_last), 32'(m_pos == m_len - 1));
    end else begin
      check_eq("last_idle", 32'(sif.out_last), 32'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  int   rdy_mode;            // 0: always ready, 1: random, 2: pattern queue
  logic rdy_pat [$];

  task automatic tick();
    @(negedge clk);
    start = 1'b0;
    case (rdy_mode)
      0:       sif.out_ready = 1'b1;
      1:       sif.out_ready = 1'($urandom_range(0, 1));
      default: sif.out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    endcase
  endtask

  task automatic do_start(input int c);
    @(negedge clk);
    start         = 1'b1;
    count         = (IW+1)'(c);
    sif.out_ready = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && m_active; k++) tick();
    check_eq("idle_timeout", 32'(m_active), 32'd0);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) in_smpls[i*DW +: DW] = DW'(12'h100 + i);
  endtask

  task automatic set_const(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) in_smpls[i*DW +: DW] = v;
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++) in_smpls[i*DW +: DW] = DW'($urandom);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    rst_n         = 1'b1;
    start         = 1'b0;
    count         = '0;
    in_smpls      = '0;
    sif.out_ready = 1'b0;
    rdy_mode      = 0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst_smpl",  32'(sif.out_smpl),  32'd0);
    check_eq("rst_idx",   32'(sif.out_idx),   32'd0);
    check_eq("rst_valid", 32'(sif.out_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame at one beat per cycle.
    set_ramp();
    rdy_mode = 0;
    do_start(14);
    wait_idle();
    tick();

    // Backpressure with ready pattern 1,0,0,1,0,1.
    rdy_mode = 2;
    rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_start(3);
    wait_idle();
    tick();

    // Snapshot isolation: bank rewritten one cycle after start.
    rdy_mode = 0;
    set_ramp();
    do_start(14);
    set_const(12'hFFF);
    wait_idle();
    tick();

    // Edge counts: 0, clamp at 15, single beat.
    set_ramp();
    do_start(0);
    tick();
    tick();
    rdy_mode = 1;
    do_start(15);
    wait_idle();
    tick();
    do_start(1);
    wait_idle();
    tick();

    // Start pulsed mid-frame must not shorten the frame.
    rdy_mode = 0;
    do_start(14);
    tick();
    tick();
    start = 1'b1;
    count = 5'd2;
    wait_idle();

    // Start on the done cycle opens the next frame one cycle later.
    do_start(3);
    for (int k = 0; k < 50 && !m_done; k++) tick();
    check_eq("done_seen", 32'(m_done), 32'd1);
    set_rand();
    start = 1'b1;
    count = 5'd4;
    tick();
    wait_idle();
    tick();

    // Asynchronous reset at beat 5, between clock edges.
    set_ramp();
    do_start(14);
    for (int k = 0; k < 50 && m_pos != 5; k++) tick();
    check_eq("beat5_reached", 32'(m_pos), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(sif.out_valid), 32'd0);
    check_eq("arst_busy",  32'(busy),          32'd0);
    check_eq("arst_done",  32'(done),          32'd0);
    check_eq("arst_last",  32'(sif.out_last),  32'd0);
    check_eq("arst_smpl",  32'(sif.out_smpl),  32'd0);
    check_eq("arst_idx",   32'(sif.out_idx),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    set_rand();
    do_start(2);
    wait_idle();
    tick();

    // Randomized frames with random backpressure, bank churn and stray starts.
    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      set_rand();
      do_start($urandom_range(0, 15));
      for (int k = 0; k < 200 && m_active; k++) begin
        tick();
        if ($urandom_range(0, 3) == 0) set_rand();
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1;
          count = (IW+1)'($urandom_range(0, 15));
        end
      end
      wait_idle();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sample_bank_reader.md
Name: sample_bank_reader

Overview:
- Read-side counterpart of the sample register bank. Takes the packed N-slot sample bus and streams the samples out one at a time, in index order.
- Uses a valid/ready handshake toward a downstream consumer (UART formatter, averager, etc.).
- Snapshots the bank when a readout starts, so sampler writes during readout cannot tear a frame.

Parameters:
- DATA_WIDTH, 12, bits per sample.
- N, 14, number of sample slots in the bank.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= N.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a readout; sampled only in IDLE.
- count  input  IDX_W+1  number of samples to read, beginning at slot 0; sampled with start.
- in_smpls  input  N*DATA_WIDTH  packed bank contents; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_smpl  output  DATA_WIDTH  current sample.
- out_idx  output  IDX_W  slot index of the current sample.
- out_last  output  1  high while the final sample of the frame is presented.
- out_valid  output  1  out_smpl, out_idx and out_last are valid.
- out_ready  input  1  consumer accepts the presented sample.
- busy  output  1  high while a readout is in progress.
- done  output  1  one-cycle pulse at the end of a readout.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: out_smpl=0, out_idx=0, out_last=0, out_valid=0, busy=0, done=0.
  - Internal: shadow copy=0, length=0, state=IDLE.
  - Reset during a readout aborts the frame; no done pulse is generated.
- States: IDLE, SEND. All outputs are registered.
- IDLE:
  - busy=0, out_valid=0.
  - On start=1 with count!=0:
    - Copy in_smpls into the shadow register.
    - len = min(count, N); idx = 0.
    - Next cycle: state=SEND, busy=1, out_valid=1, out_smpl=shadow[0].
    - Latency from start to first out_valid is exactly 1 cycle.
  - On start=1 with count=0: done=1 for exactly one cycle, 1 cycle later. busy stays 0 and no data is emitted.
  - count>N is clamped to N; the clamp is not an error.
- SEND:
  - out_smpl = shadow[idx], out_idx = idx, out_last = (idx == len-1).
  - Handshake: a transfer occurs on any edge where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - Transfer on a non-last sample: idx increments and the next sample is presented the following cycle. out_valid stays high, giving 1 sample/cycle when out_ready is held high.
  - Transfer on the last sample: the next cycle has out_valid=0, out_last=0, busy=0, done=1 (single cycle), and state=IDLE.
  - start is ignored while in SEND.
- Snapshot isolation: changes on in_smpls after the start cycle never affect the emitted data.
- Back-to-back frames: start is honoured in the cycle where done=1, because the block is already in IDLE. The earliest possible gap between frames is therefore one cycle with out_valid=0.
- out_ready is ignored when out_valid=0.
- Index arithmetic: idx never exceeds len-1, so no wrap-around can occur.

Test Plan:
- Full frame:
  - Stimulus: slot i = 0x100+i, count=14, out_ready held 1.
  - Required: valid rises 1 cycle after start; 14 consecutive beats carry 0x100..0x10D with idx 0..13; out_last only on idx 13; done on the cycle after the last beat; busy high for exactly 14 cycles.
- Backpressure:
  - Stimulus: count=3; out_ready toggles 1,0,0,1,0,1.
  - Required: each sample is held stable while out_ready=0; exactly 3 transfers occur (0x100, 0x101, 0x102); done follows the third.
- Snapshot:
  - Stimulus: start with count=14, then rewrite every slot to 0xFFF one cycle later.
  - Required: the output is still 0x100..0x10D.
- Edge counts:
  - count=0: done pulses 1 cycle after start; out_valid and busy never rise.
  - count=15: clamped to 14 beats.
  - count=1: a single beat with out_last=1.
- Start handling:
  - start pulsed mid-frame is ignored: the frame length is unchanged.
  - start pulsed on the done cycle begins a new frame whose first valid appears 1 cycle later.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 at beat 5, asynchronously between clock edges.
  - Required: all outputs go to 0 immediately with no done pulse. After release, a new start with count=2 emits slot 0 and slot 1 correctly.
